// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose: two requesters (A and B) each offer a W-bit word. A round-robin
// arbiter picks one and the word goes to a byte-wide UART transmitter,
// least-significant byte first, one transmitter frame per byte.
//
// Parameters:
//   DATA_BITS      UART character width (default 8)
//   WORD_BYTES     bytes per requester word, W = DATA_BITS*WORD_BYTES (default 4)
//   TIMEOUT_CYCLES watchdog limit in WAIT (used only with UART_ARB_TIMEOUT_EN)
//
// Optional feature macro: UART_ARB_TIMEOUT_EN
//   When defined, a watchdog in WAIT aborts the word after TIMEOUT_CYCLES
//   cycles without i_tx_done_tick. When undefined, WAIT waits forever and
//   o_timeout is tied to 0.
//
// Ports:
//   i_clock          system clock, rising edge
//   i_reset          asynchronous reset, active low
//   i_req_x          requester x word-send request (level), x = a/b
//   i_word_x         requester x word, sampled at grant
//   o_grant_x        1-cycle pulse: requester x's word captured
//   o_done_x         1-cycle pulse: requester x's last byte transmitted
//   o_tx_data        byte to the transmitter, stable through START and WAIT
//   o_tx_start       1-cycle transmit-start pulse
//   i_tx_done_tick   transmitter frame-complete pulse (honoured only in WAIT)
//   o_busy           high in every state except IDLE
//   o_timeout        1-cycle watchdog-abort pulse
//
// All outputs are registered: each is computed from the next state and
// loaded at the same edge as the state register.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int DATA_BITS      = 8,
    parameter int WORD_BYTES     = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic                            i_req_a,
    input  logic [DATA_BITS*WORD_BYTES-1:0] i_word_a,
    output logic                            o_grant_a,
    output logic                            o_done_a,
    input  logic                            i_req_b,
    input  logic [DATA_BITS*WORD_BYTES-1:0] i_word_b,
    output logic                            o_grant_b,
    output logic                            o_done_b,
    output logic [DATA_BITS-1:0]            o_tx_data,
    output logic                            o_tx_start,
    input  logic                            i_tx_done_tick,
    output logic                            o_busy,
    output logic                            o_timeout
);

    localparam int W     = DATA_BITS * WORD_BYTES;
    localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(WORD_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [W-1:0]         shift_q, shift_d;
    logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic                 owner_q, owner_d;    // 0 = A, 1 = B
    logic                 last_b_q, last_b_d;  // 1 = B was granted last

    logic                 grant_a_q, grant_a_d;
    logic                 grant_b_q, grant_b_d;
    logic                 done_a_q, done_a_d;
    logic                 done_b_q, done_b_d;
    logic                 tx_start_q, tx_start_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 busy_q, busy_d;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            timeout_q, timeout_d;
`endif

    // -------------------------------------------------------------------------
    // Next-state and registered-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d    = state_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        owner_d    = owner_q;
        last_b_d   = last_b_q;
        grant_a_d  = 1'b0;
        grant_b_d  = 1'b0;
        done_a_d   = 1'b0;
        done_b_d   = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        timeout_d  = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (i_req_a || i_req_b) begin
                    // A lone request wins outright; with both high, the side
                    // not granted last wins.
                    owner_d    = i_req_b && (!i_req_a || !last_b_q);
                    shift_d    = owner_d ? i_word_b : i_word_a;
                    byte_cnt_d = '0;
                    grant_a_d  = !owner_d;
                    grant_b_d  = owner_d;
                    state_d    = START;
                end
            end

            START: begin
`ifdef UART_ARB_TIMEOUT_EN
                to_cnt_d = '0;
`endif
                state_d = WAIT;
            end

            WAIT: begin
                if (i_tx_done_tick) begin
                    if (byte_cnt_q < LAST_BYTE) begin
                        shift_d    = shift_q >> DATA_BITS;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        state_d    = START;
                    end else begin
                        state_d = DONE;
                    end
                end
`ifdef UART_ARB_TIMEOUT_EN
                // A frame completion on the final count still wins over the
                // watchdog because it is tested first.
                else if (to_cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    last_b_d  = owner_q;
                    state_d   = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end

            DONE: begin
                done_a_d = !owner_q;
                done_b_d = owner_q;
                last_b_d = owner_q;
                state_d  = IDLE;
            end

            default: state_d = IDLE;
        endcase

        tx_start_d = (state_d == START);
        tx_data_d  = shift_d[DATA_BITS-1:0];
        busy_d     = (state_d != IDLE);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            // NOTE: the shift register is a plain register, not a memory, so it
            // is reset along with the rest of the state.
            state_q    <= IDLE;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            owner_q    <= 1'b0;
            last_b_q   <= 1'b1;  // A wins the first contested arbitration
            grant_a_q  <= 1'b0;
            grant_b_q  <= 1'b0;
            done_a_q   <= 1'b0;
            done_b_q   <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q    <= state_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            owner_q    <= owner_d;
            last_b_q   <= last_b_d;
            grant_a_q  <= grant_a_d;
            grant_b_q  <= grant_b_d;
            done_a_q   <= done_a_d;
            done_b_q   <= done_b_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    // No watchdog is built; the limit parameter is intentionally unused.
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
    assign o_timeout = 1'b0;
`endif

    assign o_grant_a  = grant_a_q;
    assign o_grant_b  = grant_b_q;
    assign o_done_a   = done_a_q;
    assign o_done_b   = done_b_q;
    assign o_tx_start = tx_start_q;
    assign o_tx_data  = tx_data_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter (DATA_BITS=8, WORD_BYTES=4,
// TIMEOUT_CYCLES=50). A transmitter responder answers every o_tx_start with a
// frame-done tick after a programmable delay. A monitor logs each started
// byte; expected byte sequences and grant order come from the words the bench
// drove and a transaction-level round-robin model. Honours
// UART_ARB_TIMEOUT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int DB = 8;
    localparam int WB = 4;
    localparam int W  = DB * WB;
    localparam int TO = 50;

    localparam int EV_GRANT_A   = 0;
    localparam int EV_GRANT_B   = 1;
    localparam int EV_GRANT_ANY = 2;
    localparam int EV_DONE_A    = 3;
    localparam int EV_DONE_B    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_a = 1'b0, req_b = 1'b0;
    logic [W-1:0]  word_a = '0, word_b = '0;
    logic          grant_a, grant_b, done_a, done_b;
    logic [DB-1:0] tx_data;
    logic          tx_start, busy, timeout;
    logic          tick_auto = 1'b0, tick_spur = 1'b0;
    logic          tick;

    assign tick = tick_auto | tick_spur;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .DATA_BITS      (DB),
        .WORD_BYTES     (WB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst_n),
        .i_req_a        (req_a),
        .i_word_a       (word_a),
        .o_grant_a      (grant_a),
        .o_done_a       (done_a),
        .i_req_b        (req_b),
        .i_word_b       (word_b),
        .o_grant_b      (grant_b),
        .o_done_b       (done_b),
        .o_tx_data      (tx_data),
        .o_tx_start     (tx_start),
        .i_tx_done_tick (tick),
        .o_busy         (busy),
        .o_timeout      (timeout)
    );

    int vectors = 0;
    int miscompares = 0;

    // ---------------- monitor ----------------
    logic [DB-1:0] start_q[$];
    int            grants_a = 0, grants_b = 0, dones_a = 0, dones_b = 0;
    int            timeouts = 0, stab_err = 0;
    logic [DB-1:0] held_byte = '0;
    bit            in_xfer = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_xfer = 1'b0;
        end else begin
            if (grant_a) grants_a++;
            if (grant_b) grants_b++;
            if (done_a) dones_a++;
            if (done_b) dones_b++;
            if (timeout) timeouts++;
            if (tx_start) begin
                start_q.push_back(tx_data);
                held_byte = tx_data;
                in_xfer   = 1'b1;
            end else if (done_a || done_b || timeout) begin
                in_xfer = 1'b0;
            end else if (in_xfer && tx_data !== held_byte) begin
                stab_err++;
            end
        end
    end

    // ---------------- transmitter responder ----------------
    bit rsp_en = 1'b1;
    int rsp_delay = 3;
    int rsp_cnt = -1;

    always @(negedge clk) begin
        tick_auto = 1'b0;
        if (!rst_n) begin
            rsp_cnt = -1;
        end else if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                tick_auto = 1'b1;
                rsp_cnt   = -1;
            end
        end
        if (rst_n && rsp_en && tx_start) rsp_cnt = rsp_delay;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_evt(input string tag, input int sel, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            case (sel)
                EV_GRANT_A:   seen = grant_a;
                EV_GRANT_B:   seen = grant_b;
                EV_GRANT_ANY: seen = grant_a | grant_b;
                EV_DONE_A:    seen = done_a;
                EV_DONE_B:    seen = done_b;
                default:      seen = 1'b0;
            endcase
        end
        check(tag, 64'(seen), 64'd1);
    endtask

    task automatic check_word(input string tag, input logic [W-1:0] word);
        check($sformatf("%s_nstarts", tag), 64'(start_q.size()), 64'(WB));
        for (int i = 0; i < WB; i++) begin
            if (i < start_q.size())
                check($sformatf("%s_byte%0d", tag, i), 64'(start_q[i]), 64'(word[DB*i +: DB]));
        end
        start_q.delete();
    endtask

    task automatic clear_counts();
        grants_a = 0; grants_b = 0; dones_a = 0; dones_b = 0; timeouts = 0;
        start_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    // ---------------- directed sequence ----------------
    logic [W-1:0] exp_word;
    bit           exp_b, got_b, last_was_b, ra, rb;
    int           n;

    initial begin
        // Reset state
        repeat (3) step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_start", 64'(tx_start), 64'd0);
        check("rst_data", 64'(tx_data), 64'd0);
        check("rst_pulses", 64'({grant_a, grant_b, done_a, done_b, timeout}), 64'd0);
        rst_n = 1'b1;
        step();

        // Single word from A, ticks 10 cycles after each start
        clear_counts();
        rsp_delay = 10;
        word_a = 32'hA1B2C3D4;
        req_a  = 1'b1;
        wait_evt("s1_grant", EV_GRANT_A, 20);
        req_a = 1'b0;
        wait_evt("s1_done", EV_DONE_A, 200);
        step();
        check("s1_busy_after", 64'(busy), 64'd0);
        check("s1_grants", 64'(grants_a), 64'd1);
        check("s1_dones", 64'(dones_a), 64'd1);
        check_word("s1", 32'hA1B2C3D4);

        // Both held from reset: A, B, A, B
        do_reset();
        clear_counts();
        last_was_b = 1'b1;
        word_a = $urandom;
        word_b = $urandom;
        req_a = 1'b1;
        req_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rsp_delay = $urandom_range(1, 4);
            wait_evt($sformatf("s2_grant%0d", k), EV_GRANT_ANY, 40);
            got_b = grant_b;
            check($sformatf("s2_owner%0d", k), 64'(got_b), 64'(k % 2));
            exp_word = got_b ? word_b : word_a;
            if (got_b) word_b = $urandom; else word_a = $urandom;
            wait_evt($sformatf("s2_done%0d", k), got_b ? EV_DONE_B : EV_DONE_A, 100);
            check_word($sformatf("s2_w%0d", k), exp_word);
            check($sformatf("s2_ngrants%0d", k), 64'(grants_a + grants_b), 64'(k + 1));
            last_was_b = got_b;
        end

        // Randomized request patterns against the round-robin model; inputs
        // are scrambled during each transfer and restored before arbitration.
        for (int k = 0; k < 12; k++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if (!ra && !rb) ra = 1'b1;
            word_a = $urandom;
            word_b = $urandom;
            req_a  = ra;
            req_b  = rb;
            rsp_delay = $urandom_range(1, 5);
            exp_b    = (ra && rb) ? !last_was_b : rb;
            exp_word = exp_b ? word_b : word_a;
            wait_evt($sformatf("s3_grant%0d", k), EV_GRANT_ANY, 40);
            got_b = grant_b;
            check($sformatf("s3_owner%0d", k), 64'(got_b), 64'(exp_b));
            step();
            req_a  = 1'($urandom_range(0, 1));
            req_b  = 1'($urandom_range(0, 1));
            word_a = $urandom;
            word_b = $urandom;
            wait_evt($sformatf("s3_done%0d", k), exp_b ? EV_DONE_B : EV_DONE_A, 100);
            check_word($sformatf("s3_w%0d", k), exp_word);
            last_was_b = exp_b;
        end
        req_a = 1'b0;
        req_b = 1'b0;
        repeat (3) step();

        // Drop request and clear word one cycle after grant
        clear_counts();
        rsp_delay = 2;
        exp_word = $urandom;
        word_a = exp_word;
        req_a  = 1'b1;
        wait_evt("s4_grant", EV_GRANT_A, 20);
        step();
        req_a  = 1'b0;
        word_a = '0;
        wait_evt("s4_done", EV_DONE_A, 100);
        check_word("s4", exp_word);

        // Spurious done ticks in IDLE and START
        repeat (2) step();
        clear_counts();
        tick_spur = 1'b1;
        step();
        tick_spur = 1'b0;
        step();
        check("s5_idle_busy", 64'(busy), 64'd0);
        check("s5_idle_nostart", 64'(start_q.size()), 64'd0);
        rsp_delay = 3;
        exp_word = $urandom;
        word_b = exp_word;
        req_b  = 1'b1;
        wait_evt("s5_grant", EV_GRANT_B, 20);
        tick_spur = 1'b1;
        step();
        tick_spur = 1'b0;
        req_b = 1'b0;
        wait_evt("s5_done", EV_DONE_B, 100);
        check_word("s5", exp_word);

        // Reset after the second byte start
        repeat (2) step();
        clear_counts();
        word_a = $urandom;
        req_a  = 1'b1;
        n = 0;
        while (start_q.size() < 2 && n < 100) begin
            step();
            n++;
        end
        check("s6_second_start", 64'(start_q.size()), 64'd2);
        rst_n = 1'b0;
        req_a = 1'b0;
        #1;
        check("s6_rst_busy", 64'(busy), 64'd0);
        check("s6_rst_start", 64'(tx_start), 64'd0);
        check("s6_rst_data", 64'(tx_data), 64'd0);
        check("s6_rst_pulses", 64'({grant_a, grant_b, done_a, done_b}), 64'd0);
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("s6_no_done", 64'(dones_a), 64'd0);
        start_q.delete();
        exp_word = $urandom;
        word_a = exp_word;
        req_a  = 1'b1;
        wait_evt("s6_grant", EV_GRANT_A, 20);
        req_a = 1'b0;
        wait_evt("s6_done", EV_DONE_A, 100);
        check_word("s6", exp_word);

        // No done tick at all: watchdog or indefinite wait
        repeat (2) step();
        clear_counts();
        rsp_en = 1'b0;
        word_a = $urandom;
        req_a  = 1'b1;
        wait_evt("s7_grant", EV_GRANT_A, 20);
        req_a = 1'b0;
        n = 0;
`ifdef UART_ARB_TIMEOUT_EN
        while (!timeout && n < 100) begin
            step();
            n++;
        end
        check("s7_timeout_seen", 64'(timeout), 64'd1);
        check("s7_timeout_delay", 64'(n), 64'(TO + 1));
        step();
        check("s7_busy_after", 64'(busy), 64'd0);
        check("s7_no_done", 64'(dones_a), 64'd0);
`else
        repeat (80) begin
            step();
            n++;
        end
        check("s7_busy_held", 64'(busy), 64'd1);
        check("s7_no_timeout", 64'(timeouts), 64'd0);
        check("s7_no_done", 64'(dones_a), 64'd0);
`endif
        check("s7_one_start", 64'(start_q.size()), 64'd1);
        rsp_en = 1'b1;
        do_reset();

        check("tx_data_stable", 64'(stab_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DATA_BITS, default 8, UART character width.
REQ-002 Parameter WORD_BYTES, default 4, bytes per requester word; word width W = DATA_BITS*WORD_BYTES.
REQ-003 Parameter TIMEOUT_CYCLES, default 200000, watchdog limit (used only with UART_ARB_TIMEOUT_EN).
REQ-004 i_clock  input  1  single system clock, rising-edge.
REQ-005 i_reset  input  1  reset, asynchronous, active-low.
REQ-006 i_req_a  input  1  requester A word-send request, level.
REQ-007 i_word_a  input  W  requester A word, sampled at grant.
REQ-008 o_grant_a  output  1  one-cycle pulse: A's word captured.
REQ-009 o_done_a  output  1  one-cycle pulse: A's last byte transmitted.
REQ-010 i_req_b, i_word_b, o_grant_b, o_done_b: identical to A, for requester B.
REQ-011 o_tx_data  output  DATA_BITS  byte to the UART transmitter.
REQ-012 o_tx_start  output  1  one-cycle transmit-start pulse to the UART transmitter.
REQ-013 i_tx_done_tick  input  1  transmitter frame-complete pulse.
REQ-014 o_busy  output  1  high in every state except IDLE.
REQ-015 o_timeout  output  1  one-cycle watchdog-abort pulse.

Function
REQ-016 FSM states SHALL be IDLE, START, WAIT, DONE; all outputs registered.
REQ-017 IDLE: on any request, the winner's word SHALL be latched into a W-bit shift register, byte counter cleared, owner recorded, o_grant_x pulsed the next cycle, next state START.
REQ-018 Arbitration SHALL be round-robin: with both requests high, the requester not granted last wins; after reset A has priority.
REQ-019 START: o_tx_start SHALL be high for exactly one cycle with o_tx_data = current low byte; next state WAIT.
REQ-020 Bytes SHALL be sent LSB first: byte 0 = word[DATA_BITS-1:0].
REQ-021 o_tx_data SHALL hold the current byte stable throughout START and WAIT.
REQ-022 WAIT: on i_tx_done_tick, if byte counter < WORD_BYTES-1, shift register shifts right by DATA_BITS, counter increments, next START; else next DONE.
REQ-023 DONE: owner's o_done_x SHALL pulse one cycle, last-grant pointer updated to owner, next IDLE.
REQ-024 Minimum gap between done of one word and grant of the next SHALL be one IDLE cycle.
REQ-025 i_tx_done_tick outside WAIT SHALL be ignored.
REQ-026 Deassertion of i_req_x or change of i_word_x after grant SHALL not affect the transfer in progress.
REQ-027 A request still high after its own done SHALL be re-arbitrated normally; if the other requester is also high, the other wins.
REQ-028 Total o_tx_start pulses per granted word SHALL equal WORD_BYTES exactly.

Reset
REQ-029 Reset low SHALL force state IDLE, last-grant pointer to B (so A wins first), shift register, counters, o_tx_data to 0, and all pulse outputs and o_busy to 0, asynchronously.
REQ-030 Reset mid-transfer SHALL abandon the word with no o_done_x pulse; operation resumes from IDLE after release.

Configuration
REQ-031 With UART_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT, cleared on entering WAIT; on reaching TIMEOUT_CYCLES without i_tx_done_tick, o_timeout pulses one cycle, no o_done_x, next IDLE with the pointer updated to the owner.
REQ-032 Without UART_ARB_TIMEOUT_EN, WAIT SHALL wait indefinitely, no counter is built, o_timeout is constant 0.

Verification
REQ-033 Reset, i_req_a=1, i_word_a=32'hA1B2C3D4, done tick 10 cycles after each start -> o_grant_a once; starts with o_tx_data D4, C3, B2, A1; o_done_a once; o_busy low after.
REQ-034 i_req_a and i_req_b high together from reset, held -> grant order A, B, A, B; never two consecutive grants to the same requester.
REQ-035 Drop i_req_a and change i_word_a to 0 one cycle after o_grant_a -> all four original bytes still sent, o_done_a pulses.
REQ-036 Spurious i_tx_done_tick in IDLE and START -> no state change, no extra o_tx_start, still exactly 4 starts per word.
REQ-037 Reset asserted after the second byte start -> outputs zero immediately, no o_done_a; after release, new request restarts at byte 0.
REQ-038 With UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=50, no done tick -> o_timeout pulse 50 cycles after entering WAIT, return to IDLE; without the macro, o_busy stays high.
